// File: rtl/hyper_word_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : hyper_word_responder_if
// Description : Word-level HyperBus pad-side bundle between controller and
//               responder (one 16-bit DDR word per CK period).
// Revision    : 1.0 - initial release
// ============================================================================
interface hyper_word_responder_if;
    logic        hyper_cs_ni;
    logic [15:0] hyper_dq_i;
    logic        hyper_dq_oe_i;
    logic [1:0]  hyper_rwds_i;
    logic        hyper_rwds_oe_i;
    logic [15:0] hyper_dq_o;
    logic        hyper_dq_oe_o;
    logic [1:0]  hyper_rwds_o;

    modport master (
        output hyper_cs_ni,
        output hyper_dq_i,
        output hyper_dq_oe_i,
        output hyper_rwds_i,
        output hyper_rwds_oe_i,
        input  hyper_dq_o,
        input  hyper_dq_oe_o,
        input  hyper_rwds_o
    );

    modport slave (
        input  hyper_cs_ni,
        input  hyper_dq_i,
        input  hyper_dq_oe_i,
        input  hyper_rwds_i,
        input  hyper_rwds_oe_i,
        output hyper_dq_o,
        output hyper_dq_oe_o,
        output hyper_rwds_o
    );
endinterface
`default_nettype wire

// File: rtl/hyper_word_responder.sv
`default_nettype none
// ============================================================================
// Module      : hyper_word_responder
// Description : Word-level HyperBus memory responder: CA decode, fixed initial
//               latency, linear/wrapped bursts over word memory + ID/CFG regs.
// Revision    : 1.0 - initial release
// ============================================================================
module hyper_word_responder #(
    parameter int unsigned MEM_AWIDTH = 10,
    parameter int unsigned LATENCY    = 6,
    parameter logic [15:0] ID_VAL     = 16'h0C81,
    parameter logic [15:0] CFG_RST    = 16'h8F1F
) (
    input  logic                   sys_clk_i,
    input  logic                   rstn_i,
    hyper_word_responder_if.slave  bus,
    output logic                   evt_done_o,
    output logic                   evt_err_o
);

    localparam int unsigned     c_LW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [c_LW-1:0] c_LAT_LOAD = c_LW'(LATENCY - 1);
    localparam int unsigned     c_DEPTH    = 1 << MEM_AWIDTH;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CA    = 3'd1;
    localparam logic [2:0] S_LAT   = 3'd2;
    localparam logic [2:0] S_WDATA = 3'd3;
    localparam logic [2:0] S_RDATA = 3'd4;

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic                  r_ca_sel;
    logic [15:0]           r_ca_hi;
    logic [15:0]           r_ca_mid;
    logic                  r_rd;
    logic                  r_reg;
    logic                  r_lin;
    logic [MEM_AWIDTH-1:0] r_addr;
    logic [c_LW-1:0]       r_lat_cnt;
    logic                  r_xfer;
    logic [15:0]           r_cfg;
    logic [15:0]           r_mem [0:c_DEPTH-1];
    logic [15:0]           r_dq;
    logic                  r_dq_oe;
    logic                  r_done;
    logic                  r_err;

    logic                  w_sel;
    logic                  w_ca_done;
    logic                  w_lat_end;
    logic [31:0]           w_ca_addr;
    logic [MEM_AWIDTH-1:0] w_dec_addr;
    logic [MEM_AWIDTH-1:0] w_addr_wrap;
    logic [MEM_AWIDTH-1:0] w_addr_nxt;
    logic [1:0]            w_mask;
    logic [15:0]           w_mem_rd;
    logic [15:0]           w_rd_word;
    logic                  w_fetch;
    logic                  w_wr;
    logic [15:0]           w_dq_nxt;
    logic                  w_dq_oe_nxt;
    logic                  w_done_nxt;
    logic                  w_err_nxt;
    logic                  w_unused_ok;

    assign w_sel      = ~bus.hyper_cs_ni;
    assign w_ca_done  = (r_state == S_CA) && w_sel && r_ca_sel;
    assign w_lat_end  = (r_state == S_LAT) && w_sel && (r_lat_cnt == '0);
    // Third CA word is still on the bus when decoding, so take it live.
    assign w_ca_addr  = {r_ca_hi[12:0], r_ca_mid, bus.hyper_dq_i[2:0]};
    assign w_dec_addr = w_ca_addr[MEM_AWIDTH-1:0];
    assign w_unused_ok = ^w_ca_addr;

    generate
        if (MEM_AWIDTH > 4) begin : g_wrap_hi
            assign w_addr_wrap = {r_addr[MEM_AWIDTH-1:4], r_addr[3:0] + 4'd1};
        end else begin : g_wrap_small
            assign w_addr_wrap = r_addr + MEM_AWIDTH'(1);
        end
    endgenerate

    assign w_addr_nxt = r_lin ? (r_addr + MEM_AWIDTH'(1)) : w_addr_wrap;
    assign w_mask     = bus.hyper_rwds_oe_i ? bus.hyper_rwds_i : 2'b00;
    assign w_mem_rd   = r_mem[r_addr];
    assign w_rd_word  = r_reg ? (r_addr[0] ? r_cfg : ID_VAL) : w_mem_rd;

    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_sel) w_state_nxt = S_CA;
            end
            S_CA: begin
                if (!w_sel) begin
                    w_state_nxt = S_IDLE;
                end else if (r_ca_sel) begin
                    // Register writes skip the initial latency entirely.
                    w_state_nxt = (!r_ca_hi[15] && r_ca_hi[14]) ? S_WDATA : S_LAT;
                end
            end
            S_LAT: begin
                if (!w_sel) begin
                    w_state_nxt = S_IDLE;
                end else if (r_lat_cnt == '0) begin
                    w_state_nxt = r_rd ? S_RDATA : S_WDATA;
                end
            end
            S_WDATA, S_RDATA: begin
                if (!w_sel) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_fetch     = (w_lat_end && r_rd) || ((r_state == S_RDATA) && w_sel);
        w_wr        = (r_state == S_WDATA) && w_sel && bus.hyper_dq_oe_i;
        w_dq_oe_nxt = w_fetch;
        w_dq_nxt    = w_fetch ? w_rd_word : 16'h0000;
        w_done_nxt  = ((r_state == S_WDATA) || (r_state == S_RDATA)) && !w_sel && r_xfer;
        w_err_nxt   = ((r_state == S_CA) || (r_state == S_LAT)) && !w_sel;
    end

    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_ca_sel  <= 1'b0;
            r_ca_hi   <= 16'h0000;
            r_ca_mid  <= 16'h0000;
            r_rd      <= 1'b0;
            r_reg     <= 1'b0;
            r_lin     <= 1'b0;
            r_addr    <= '0;
            r_lat_cnt <= '0;
            r_xfer    <= 1'b0;
            r_cfg     <= CFG_RST;
            r_dq      <= 16'h0000;
            r_dq_oe   <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_dq    <= w_dq_nxt;
            r_dq_oe <= w_dq_oe_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;

            if ((r_state == S_IDLE) && w_sel) begin
                r_ca_hi  <= bus.hyper_dq_i;
                r_ca_sel <= 1'b0;
            end else if ((r_state == S_CA) && w_sel && !r_ca_sel) begin
                r_ca_mid <= bus.hyper_dq_i;
                r_ca_sel <= 1'b1;
            end

            if (w_ca_done) begin
                r_rd      <= r_ca_hi[15];
                r_reg     <= r_ca_hi[14];
                r_lin     <= r_ca_hi[13];
                r_addr    <= w_dec_addr;
                r_lat_cnt <= c_LAT_LOAD;
                r_xfer    <= 1'b0;
            end else begin
                if ((r_state == S_LAT) && w_sel && (r_lat_cnt != '0)) begin
                    r_lat_cnt <= r_lat_cnt - c_LW'(1);
                end
                if (w_fetch || w_wr) begin
                    r_addr <= w_addr_nxt;
                end
                if (w_wr || ((r_state == S_RDATA) && w_sel)) begin
                    r_xfer <= 1'b1;
                end
            end

            if (w_wr && r_reg && r_addr[0]) begin
                if (!w_mask[1]) r_cfg[15:8] <= bus.hyper_dq_i[15:8];
                if (!w_mask[0]) r_cfg[7:0]  <= bus.hyper_dq_i[7:0];
            end
        end
    end

    // Word memory is deliberately never reset.
    always_ff @(posedge sys_clk_i) begin
        if (w_wr && !r_reg) begin
            if (!w_mask[1]) r_mem[r_addr][15:8] <= bus.hyper_dq_i[15:8];
            if (!w_mask[0]) r_mem[r_addr][7:0]  <= bus.hyper_dq_i[7:0];
        end
    end

    assign bus.hyper_dq_o    = r_dq;
    assign bus.hyper_dq_oe_o = r_dq_oe;
    assign bus.hyper_rwds_o  = {r_dq_oe, 1'b0};
    assign evt_done_o        = r_done;
    assign evt_err_o         = r_err;

endmodule
`default_nettype wire
